// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared constants, TX state type and byte-lane mapping for usb_word_bridge
// Purpose : common definitions imported by usb_word_fifo and usb_word_bridge.
// Contents: BYTE_W, tx_state_t {TX_IDLE, TX_SHIFT}, lane_sel(idx, word_bytes).
// Macro   : USB_BRIDGE_MSB_FIRST_EN selects MSB-first lane order (default LSB-first).
package usb_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {
      TX_IDLE  = 1'b0,
      TX_SHIFT = 1'b1
   } tx_state_t;

   // Maps the position of a byte in the serial stream to its lane in the word.
   function automatic int lane_sel(input int idx, input int word_bytes);
`ifdef USB_BRIDGE_MSB_FIRST_EN
      return word_bytes - 1 - idx;
`else
      return (idx < word_bytes) ? idx : 0;
`endif
   endfunction

endpackage

// File: rtl/usb_word_fifo.sv
// rtl/usb_word_fifo.sv - RX word FIFO with push-while-full-and-popping support
// Purpose : small synchronous FIFO buffering assembled RX words.
// Ports   : clk, rst (sync, active-high), push/push_data, pop, rd_data (head),
//           empty, push_drop (push rejected because FIFO was full and not popping).
module usb_word_fifo #(
   parameter int W        = 32,
   parameter int RX_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] rd_data,
   output logic         empty,
   output logic         push_drop
);

   localparam int AW = $clog2(RX_DEPTH);

   logic [W-1:0]  mem_q [RX_DEPTH];
   logic [W-1:0]  mem_d [RX_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full, pop_ok, push_ok;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(RX_DEPTH));
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      pop_ok   = pop && !empty;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push_ok   = push && (!full || pop_ok);
      push_drop = push && !push_ok;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RX_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/usb_word_bridge.sv
// rtl/usb_word_bridge.sv - byte/word bridge between USB byte interface and stock datapath
// Purpose : RX assembles WORD_BYTES bytes into words buffered in usb_word_fifo;
//           TX serialises average_data into bytes under a byte_ack handshake.
// Ports   : clk, rst (sync, active-high);
//           RX: new_byte, data_in -> stock_data, data_ready, stock_ack, rx_overflow, ovf_clr;
//           TX: average_data, output_ready -> tx_busy, data_out, shift_out, byte_ack.
// Macro   : USB_BRIDGE_MSB_FIRST_EN selects MSB-first lane order (via usb_pkg::lane_sel).
module usb_word_bridge
   import usb_pkg::*;
#(
   parameter int WORD_BYTES = 4,
   parameter int RX_DEPTH   = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         new_byte,
   input  logic [7:0]                   data_in,
   output logic [WORD_BYTES*BYTE_W-1:0] stock_data,
   output logic                         data_ready,
   input  logic                         stock_ack,
   output logic                         rx_overflow,
   input  logic                         ovf_clr,
   input  logic [WORD_BYTES*BYTE_W-1:0] average_data,
   input  logic                         output_ready,
   output logic                         tx_busy,
   output logic [7:0]                   data_out,
   output logic                         shift_out,
   input  logic                         byte_ack
);

   localparam int W  = WORD_BYTES * BYTE_W;
   localparam int IW = $clog2(WORD_BYTES);

   // ---------------- RX assembly ----------------
   logic [IW-1:0] bcnt_q, bcnt_d;
   logic [W-1:0]  asm_q, asm_d;
   logic          push, drop, fifo_empty;
   logic          ovf_q, ovf_d;

   always_comb begin
      asm_d  = asm_q;
      bcnt_d = bcnt_q;
      push   = 1'b0;
      if (new_byte) begin
         asm_d[lane_sel(int'(bcnt_q), WORD_BYTES)*BYTE_W +: BYTE_W] = data_in;
         if (bcnt_q == IW'(WORD_BYTES-1)) begin
            // asm_d already carries the final byte, so it is the word pushed.
            push   = 1'b1;
            bcnt_d = '0;
         end else begin
            bcnt_d = bcnt_q + 1'b1;
         end
      end
      ovf_d = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;
   end

   usb_word_fifo #(
      .W        (W),
      .RX_DEPTH (RX_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (asm_d),
      .pop       (stock_ack),
      .rd_data   (stock_data),
      .empty     (fifo_empty),
      .push_drop (drop)
   );

   assign data_ready  = !fifo_empty;
   assign rx_overflow = ovf_q;

   // ---------------- TX serialiser ----------------
   tx_state_t     state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0]  word_q, word_d;
   logic [7:0]    dout_q, dout_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      word_d  = word_q;
      dout_d  = dout_q;
      case (state_q)
         TX_IDLE: begin
            if (output_ready) begin
               word_d  = average_data;
               idx_d   = '0;
               dout_d  = average_data[lane_sel(0, WORD_BYTES)*BYTE_W +: BYTE_W];
               state_d = TX_SHIFT;
            end
         end
         TX_SHIFT: begin
            if (byte_ack) begin
               if (idx_q == IW'(WORD_BYTES-1)) begin
                  idx_d   = '0;
                  dout_d  = '0;
                  state_d = TX_IDLE;
               end else begin
                  idx_d  = idx_q + 1'b1;
                  // Pre-select the next lane so data_out is a plain register.
                  dout_d = word_q[lane_sel(int'(idx_q) + 1, WORD_BYTES)*BYTE_W +: BYTE_W];
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   assign tx_busy   = (state_q == TX_SHIFT);
   assign shift_out = (state_q == TX_SHIFT);
   assign data_out  = dout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         bcnt_q  <= '0;
         asm_q   <= '0;
         ovf_q   <= 1'b0;
         state_q <= TX_IDLE;
         idx_q   <= '0;
         word_q  <= '0;
         dout_q  <= '0;
      end else begin
         bcnt_q  <= bcnt_d;
         asm_q   <= asm_d;
         ovf_q   <= ovf_d;
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         dout_q  <= dout_d;
      end
   end

endmodule
